// File: rtl/gate_arb_pkg.sv
// Shared definitions for the round-robin demux gate arbiter slice.
package gate_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;

    localparam logic OP_XOR  = 1'b0;
    localparam logic OP_XNOR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/xor_xnor_using_demux.sv
// XOR/XNOR built from a 1-to-4 demux of a constant one, selected by {a,b}.
module xor_xnor_using_demux (
    input  logic a,
    input  logic b,
    output logic y_xor,
    output logic y_xnor
);

    logic [3:0] line;

    always_comb begin
        line        = '0;
        line[{a, b}] = 1'b1;
    end

    assign y_xor  = line[1] | line[2];
    assign y_xnor = line[0] | line[3];

endmodule

// File: rtl/demux_gate_arbiter.sv
// Round-robin arbiter sharing one demux XOR/XNOR unit among NUM_REQ requesters.
module demux_gate_arbiter
    import gate_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] a_in,
    input  logic [NUM_REQ-1:0] b_in,
    input  logic [NUM_REQ-1:0] op_sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic               result,
    output logic               busy,
    output logic [CNT_W-1:0]   eval_count
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t           state;
    logic [IDX_W-1:0] last_gnt;
    logic [IDX_W-1:0] win_q;
    logic [IDX_W-1:0] pick;
    logic             a_q, b_q, op_q;
    logic             res_q;
    logic             g_xor, g_xnor;

    // First set request bit at or after last+1, wrapping past NUM_REQ-1.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [IDX_W-1:0]   last
    );
        logic [IDX_W-1:0] sel;
        logic             found;
        int unsigned      idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && r[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(req, last_gnt);

    xor_xnor_using_demux u_gate (
        .a      (a_q),
        .b      (b_q),
        .y_xor  (g_xor),
        .y_xnor (g_xnor)
    );

    assign result = res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            done       <= '0;
            res_q      <= 1'b0;
            busy       <= 1'b0;
            eval_count <= '0;
            last_gnt   <= IDX_W'(NUM_REQ - 1);
            win_q      <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            op_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= '0;
                    if (|req) begin
                        win_q <= pick;
                        gnt   <= NUM_REQ'(1) << pick;
                        a_q   <= a_in[pick];
                        b_q   <= b_in[pick];
                        op_q  <= op_sel[pick];
                        busy  <= 1'b1;
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    res_q <= (op_q == OP_XNOR) ? g_xnor : g_xor;
                    done  <= gnt;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    last_gnt <= win_q;
                    if (eval_count != '1)
                        eval_count <= eval_count + 1'b1;
                    gnt   <= '0;
                    done  <= '0;
                    res_q <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    done  <= '0;
                    res_q <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_gate_arbiter.sv
// Directed self-checking bench for demux_gate_arbiter.
module tb_demux_gate_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, a_in, b_in, op_sel;
    logic [3:0] gnt, done, gnt4, done4;
    logic       result, busy, result4, busy4;
    logic [15:0] eval_count;
    logic [3:0]  eval_count4;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demux_gate_arbiter #(.NUM_REQ(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .op_sel(op_sel),
        .gnt(gnt), .done(done), .result(result), .busy(busy), .eval_count(eval_count)
    );

    demux_gate_arbiter #(.NUM_REQ(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .op_sel(op_sel),
        .gnt(gnt4), .done(done4), .result(result4), .busy(busy4), .eval_count(eval_count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Single-requester transaction with full latency checks.
    task automatic do_one(input int idx, input logic a, input logic b, input logic op);
        logic exp;
        exp         = (a ^ b) ^ op;
        a_in[idx]   = a;
        b_in[idx]   = b;
        op_sel[idx] = op;
        req         = 4'b0001 << idx;
        tick();
        check("gnt_c1", gnt, 4'b0001 << idx);
        check("busy_c1", busy, 1'b1);
        check("done_c1", done, 4'b0000);
        a_in[idx] = ~a;
        b_in[idx] = ~b;
        tick();
        check("gnt_c2", gnt, 4'b0001 << idx);
        check("done_c2", done, 4'b0001 << idx);
        check("result_c2", result, exp);
        req = 4'b0000;
        tick();
        check("idle_gnt", gnt, 4'b0000);
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 4'b0000);
    endtask

    task automatic wait_done(output logic [3:0] d, output int t);
        d = 4'b0000;
        t = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done != 4'b0000) begin
                d = done;
                t = cyc;
                break;
            end
        end
        if (d == 4'b0000) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [3:0] d;
        int         t, t_prev;
        int         exp_seq[4];

        req = '0; a_in = '0; b_in = '0; op_sel = '0;
        do_reset();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_done", done, 4'b0000);
        check("rst_result", result, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", eval_count, 16'd0);

        do_one(0, 1'b1, 1'b0, 1'b0);
        check("count_1", eval_count, 16'd1);

        do_reset();
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            do_one(2, v[2], v[1], v[0]);
        end
        check("count_8", eval_count, 16'd8);

        // All four requesting: 0,1,2,3 with done pulses 3 cycles apart.
        do_reset();
        a_in = 4'b0101; b_in = 4'b0011; op_sel = 4'b1100;
        req  = 4'b1111;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_done(d, t);
            check("rr4_done", d, 4'b0001 << k);
            check("rr4_result", result, (a_in[k] ^ b_in[k]) ^ op_sel[k]);
            if (k > 0) check("rr4_spacing", t - t_prev, 3);
            t_prev = t;
            req[k] = 1'b0;
        end
        tick();
        check("rr4_idle", busy, 1'b0);

        // Two requesters held forever must alternate.
        do_reset();
        req = 4'b1001;
        exp_seq = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
        for (int k = 0; k < 4; k++) begin
            wait_done(d, t);
            check("alt_done", d, exp_seq[k]);
        end
        req = 4'b0000;
        for (int k = 0; k < 3; k++) tick();
        check("alt_idle", busy, 1'b0);

        // Reset during EVAL aborts the transaction.
        req = 4'b0100;
        tick();
        check("abort_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        check("abort_gnt", gnt, 4'b0000);
        check("abort_busyclr", busy, 1'b0);
        check("abort_done", done, 4'b0000);
        check("abort_count", eval_count, 16'd0);
        tick();
        check("abort_nextgnt", gnt, 4'b0001);
        tick();
        check("abort_nextdone", done, 4'b0001);
        req = 4'b0000;
        tick();
        check("abort_count1", eval_count, 16'd1);

        // Saturation on the 4-bit counter instance.
        do_reset();
        for (int k = 0; k < 20; k++) do_one(k % 4, 1'b1, 1'b1, 1'b1);
        check("sat_count4", eval_count4, 4'hF);
        check("sat_count16", eval_count, 16'd20);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
